// File: rtl/sync_pkg.sv
// Shared types and defaults for the synchronizer consumer stage.
package sync_pkg;

  // Debounce FSM states: settled low, qualifying a rise, settled high, qualifying a fall.
  typedef enum logic [1:0] {
    STABLE_LO,
    CHK_HI,
    STABLE_HI,
    CHK_LO
  } state_e;

  localparam int unsigned DEF_STABLE_CYCLES = 4;
  localparam int unsigned DEF_GLITCH_W      = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q;

  // Clear beats increment; increment stops at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sync_debounce_edge.sv
// Debounces an already-synchronized level, produces rise/fall pulses and
// counts rejected glitches.
module sync_debounce_edge
  import sync_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES) + 1,
  parameter int unsigned GLITCH_W      = DEF_GLITCH_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sync_in,
  input  logic                glitch_clr,
  output logic                level_out,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  // Count value reached on the sample just before the accepting one.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             glitch_inc;

  // State, stability counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next-state logic; pulses default low so they only last one cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    level_d    = level_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_inc = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (sync_in) begin
          state_d = CHK_HI;
          cnt_d   = CNT_W'(1);
        end
      end
      CHK_HI: begin
        if (!sync_in) begin
          state_d    = STABLE_LO;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE_HI: begin
        if (!sync_in) begin
          state_d = CHK_LO;
          cnt_d   = CNT_W'(1);
        end
      end
      CHK_LO: begin
        if (sync_in) begin
          state_d    = STABLE_HI;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  sat_counter #(
    .W (GLITCH_W)
  ) u_glitch_cnt (
    .clk (clk),
    .rst (rst),
    .inc (glitch_inc),
    .clr (glitch_clr),
    .cnt (glitch_cnt)
  );

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Bench for sync_debounce_edge: directed scenarios plus randomized toggling,
// checked every cycle against a run-length reference model. A second DUT with
// a 2-bit glitch counter shares the stimulus to exercise saturation.
module tb_sync_debounce_edge;

  localparam int STABLE = 4;
  localparam int GA_MAX = 255;
  localparam int GB_MAX = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sync_in = 1'b1;
  logic       glitch_clr = 1'b0;

  logic       level_a, rise_a, fall_a;
  logic [7:0] gcnt_a;
  logic       level_b, rise_b, fall_b;
  logic [1:0] gcnt_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sync_debounce_edge #(
    .STABLE_CYCLES (STABLE),
    .GLITCH_W      (8)
  ) dut_a (
    .clk        (clk),
    .rst        (rst),
    .sync_in    (sync_in),
    .glitch_clr (glitch_clr),
    .level_out  (level_a),
    .rise_pulse (rise_a),
    .fall_pulse (fall_a),
    .glitch_cnt (gcnt_a)
  );

  sync_debounce_edge #(
    .STABLE_CYCLES (STABLE),
    .GLITCH_W      (2)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .sync_in    (sync_in),
    .glitch_clr (glitch_clr),
    .level_out  (level_b),
    .rise_pulse (rise_b),
    .fall_pulse (fall_b),
    .glitch_cnt (gcnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: the level flips once STABLE consecutive samples differ
  // from it; any shorter run of differing samples is one glitch.
  logic m_level = 1'b0;
  int   m_run   = 0;
  logic m_rise  = 1'b0;
  logic m_fall  = 1'b0;
  int   m_ga    = 0;
  int   m_gb    = 0;
  logic m_glitch;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_level = 1'b0; m_run = 0; m_rise = 1'b0; m_fall = 1'b0; m_ga = 0; m_gb = 0;
    end else begin
      m_glitch = 1'b0;
      m_rise   = 1'b0;
      m_fall   = 1'b0;
      if (sync_in != m_level) begin
        m_run++;
        if (m_run == STABLE) begin
          m_level = sync_in;
          m_run   = 0;
          if (sync_in) m_rise = 1'b1;
          else         m_fall = 1'b1;
        end
      end else if (m_run > 0) begin
        m_glitch = 1'b1;
        m_run    = 0;
      end
      if (glitch_clr) begin
        m_ga = 0;
        m_gb = 0;
      end else if (m_glitch) begin
        if (m_ga < GA_MAX) m_ga++;
        if (m_gb < GB_MAX) m_gb++;
      end
    end
  end

  // Every-cycle comparison of both DUTs against the model.
  always @(posedge clk) begin
    #1;
    chk("model_level_a", level_a, m_level);
    chk("model_rise_a",  rise_a,  m_rise);
    chk("model_fall_a",  fall_a,  m_fall);
    chk("model_gcnt_a",  gcnt_a,  m_ga);
    chk("model_level_b", level_b, m_level);
    chk("model_gcnt_b",  gcnt_b,  m_gb);
    chk("pulse_excl",    rise_a & fall_a, 1'b0);
  end

  // Drive inputs (called at posedge+1 or later) and advance one edge.
  task automatic step(input logic s, input logic c);
    sync_in    = s;
    glitch_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic lvl, input logic r,
                            input logic f, input int ga, input int gb);
    chk({tag, "_level"}, level_a, lvl);
    chk({tag, "_rise"},  rise_a,  r);
    chk({tag, "_fall"},  fall_a,  f);
    chk({tag, "_gcnt_a"}, gcnt_a, ga);
    chk({tag, "_gcnt_b"}, gcnt_b, gb);
  endtask

  initial begin
    void'($urandom(32'h5eed_1234));

    // 1. reset with sync_in high, then full qualification
    @(posedge clk); #1;
    expect_out("reset", 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1, 0);
      expect_out("t1_qual", 0, 0, 0, 0, 0);
    end
    step(1, 0); expect_out("t1_rise", 1, 1, 0, 0, 0);
    step(1, 0); expect_out("t1_after", 1, 0, 0, 0, 0);

    // 2. back to low, then three short high glitches
    for (int i = 0; i < 3; i++) begin
      step(0, 0);
      expect_out("t2_fallq", 1, 0, 0, 0, 0);
    end
    step(0, 0); expect_out("t2_fall", 0, 0, 1, 0, 0);
    for (int g = 1; g <= 3; g++) begin
      step(1, 0); step(1, 0); step(0, 0);
      expect_out("t2_glitch", 0, 0, 0, g, g);
    end

    // 3. rise, two blips during CHK_LO, then a real fall
    step(1, 0); step(1, 0); step(1, 0);
    step(1, 0); expect_out("t3_rise", 1, 1, 0, 3, 3);
    step(0, 0); step(1, 0); expect_out("t3_blip1", 1, 0, 0, 4, 3);
    step(0, 0); step(1, 0); expect_out("t3_blip2", 1, 0, 0, 5, 3);
    step(0, 0); step(0, 0); step(0, 0);
    expect_out("t3_fallq", 1, 0, 0, 5, 3);
    step(0, 0); expect_out("t3_fall", 0, 0, 1, 5, 3);

    // 4. saturation on the narrow counter, then clear colliding with a glitch
    step(1, 0); step(0, 0);
    step(1, 0); step(0, 0); expect_out("t4_sat", 0, 0, 0, 7, 3);
    step(1, 0); step(0, 1); expect_out("t4_clr", 0, 0, 0, 0, 0);
    step(0, 0); expect_out("t4_hold", 0, 0, 0, 0, 0);

    // 5. reset mid CHK_HI, then mid rise pulse
    step(1, 0); step(0, 0); expect_out("t5_pre", 0, 0, 0, 1, 1);
    step(1, 0); step(1, 0);
    #1 rst = 1'b1;
    #1 expect_out("t5_rst_chk", 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1, 0);
      expect_out("t5_requal", 0, 0, 0, 0, 0);
    end
    step(1, 0); expect_out("t5_rise", 1, 1, 0, 0, 0);
    #1 rst = 1'b1;
    #1 expect_out("t5_rst_pulse", 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    step(0, 0); expect_out("t5_after", 0, 0, 0, 0, 0);

    // 6. randomized runs of varying length, occasional clear and reset
    for (int cyc = 0; cyc < 200; ) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        step(v, ($urandom_range(0, 19) == 0));
        cyc++;
      end
      if ($urandom_range(0, 29) == 0) begin
        #1 rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
      end
    end

    step(0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
